// File: rtl/const_lut_prog_if.sv
// Bus bundle for the programmable constant table: registered read port,
// loader write port and the sticky lock/status signals.
interface const_lut_prog_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              lock;
  logic              locked;
  logic              wr_err;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, lock,
    input  rd_data, rd_valid, locked, wr_err
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, lock,
    output rd_data, rd_valid, locked, wr_err
  );
endinterface

// File: rtl/const_lut_prog.sv
// Programmable constant table: DEPTH x WIDTH entries with a boot set restored
// on reset, one registered read per cycle, one write port and a sticky lock.
//
// state    | meaning
// UNLOCKED | writes commit to the table
// LOCKED   | table frozen until reset; writes raise wr_err
module const_lut_prog #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input logic             clk,
  input logic             reset,
  const_lut_prog_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t      state, state_nxt;
  logic             wr_ok;
  logic [WIDTH-1:0] lut_q [DEPTH];

  // Boot constants are 8-bit; narrower tables keep the low bits, wider ones zero-extend.
  function automatic logic [WIDTH-1:0] boot_val(input int idx);
    logic [7:0]       b;
    logic [WIDTH+7:0] w;
    case (idx)
      0:       b = 8'd1;
      1:       b = 8'd2;
      2:       b = 8'd15;
      3:       b = 8'hFF;
      4:       b = 8'h7F;
      5:       b = 8'd10;
      6:       b = 8'd6;
      7:       b = 8'd5;
      default: b = 8'd0;
    endcase
    w = {{WIDTH{1'b0}}, b};
    return w[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= UNLOCKED;
    else       state <= state_nxt;
  end

  // A write sampled together with the first lock still commits.
  always_comb begin
    state_nxt = state;
    wr_ok     = 1'b0;
    case (state)
      UNLOCKED: begin
        wr_ok = bus.wr_en;
        if (bus.lock) state_nxt = LOCKED;
      end
      LOCKED:   state_nxt = LOCKED;
      default:  state_nxt = UNLOCKED;
    endcase
  end

  assign bus.locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) lut_q[i] <= boot_val(i);
    end else if (wr_ok) begin
      lut_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      bus.wr_err   <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      bus.wr_err   <= bus.wr_en && (state == LOCKED);
      // Same-address write-first bypass; a blocked write leaves the old entry visible.
      if (bus.rd_en) begin
        if (wr_ok && (bus.wr_addr == bus.rd_addr)) bus.rd_data <= bus.wr_data;
        else                                       bus.rd_data <= lut_q[bus.rd_addr];
      end
    end
  end
endmodule
